s2p_deser: RTL and testbench
============================

Name: s2p_deser

Overview:
- Single-clock serial-to-parallel converter.
- Collects WIDTH serial bits on da while the active-low write strobe wra_n is asserted, then presents them as a parallel word on db with a one-cycle wrb pulse.
- Sits between a bit-serial producer and a word-wide consumer; both operate on clka.

Parameters:
- WIDTH, 8, number of serial bits per parallel word (minimum 2).
- MSB_FIRST, 1, 1 = first received bit lands in db[WIDTH-1]; 0 = first received bit lands in db[0].

Ports:
- clka  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- wra_n  input  1  active-low serial write enable; da is sampled only while low.
- da  input  1  serial data bit.
- wrb  output  1  parallel-word-valid pulse, high for exactly one clka cycle per completed word.
- db  output  WIDTH  parallel data word; holds its value until the next word completes.

Behaviour:
- Interface: one clock (clka); reset rstn is asynchronous and active-low.
- Reset (rstn low, immediately, no clock required):
  - wrb = 0, db = 0.
  - Shift register = 0, bit counter = 0.
- Sampling: at each clka rising edge with wra_n = 0, da is captured into the shift register and the bit counter increments.
- Bit placement:
  - MSB_FIRST = 1: shift left, new bit enters bit 0.
  - MSB_FIRST = 0: shift right, new bit enters bit WIDTH-1.
- Word completion: at the edge that samples bit number WIDTH (counter = WIDTH-1):
  - db is loaded with the full word, including the bit sampled on that edge.
  - wrb is set to 1.
  - Counter wraps to 0.
- wrb timing and latency:
  - wrb is registered and is high during the single cycle following the completing edge; it returns to 0 on the next edge unless another word completes there.
  - Latency from the sampling edge of the last bit to wrb/db valid is one clock edge (the same edge; outputs are registered).
- Back-to-back frames: with wra_n held low continuously, a new word completes every WIDTH cycles and wrb pulses once every WIDTH cycles. No idle cycle is required between frames.
- Frame abort: at any edge with wra_n = 1:
  - Counter clears to 0 and the partial word is discarded.
  - db and wrb are not updated by the abort; wrb still drops to 0 on that edge if it was high.
  - The next wra_n low cycle starts a new frame at bit 1.
- da while wra_n = 1: ignored, including X/Z values. Outputs must not change.
- Reset mid-frame: partial bits are lost and db clears to 0. After release, the first sampled bit is bit 1 of a new frame.
- wra_n held high indefinitely: db retains the last completed word and wrb stays 0.
- Counter width: ceil(log2(WIDTH)) bits; it never exceeds WIDTH-1.
- No combinational path from inputs to outputs.

Test Plan:
- Reset check:
  - Stimulus: assert rstn low asynchronously mid-cycle.
  - Required: wrb = 0 and db = 8'h00 immediately, with no clock edge needed.
- Single frame, MSB_FIRST = 1:
  - Stimulus: wra_n = 0 for 8 edges with da = 1,0,1,1,0,0,1,0, then wra_n = 1.
  - Required: after the 8th edge, db = 8'hB2 and wrb = 1 for exactly one cycle; db then holds 8'hB2.
- Back-to-back frames:
  - Stimulus: wra_n low for 16 edges, first word 8'hFF, second word 8'h01.
  - Required: wrb pulses at edge 8 with db = 8'hFF and at edge 16 with db = 8'h01; wrb is low on all other cycles.
- Abort mid-frame:
  - Stimulus: after a completed word 8'hA5, send 3 bits, raise wra_n for 2 cycles, then send 8 bits 8'h3C.
  - Required: no wrb pulse for the partial word; db stays 8'hA5 until wrb pulses with db = 8'h3C.
- LSB-first build (MSB_FIRST = 0):
  - Stimulus: da = 1,0,0,0,0,0,0,0.
  - Required: db = 8'h01 with one wrb pulse.
- Reset mid-frame:
  - Stimulus: send 5 bits, pulse rstn low, then send 8 bits 8'h81.
  - Required: db = 8'h00 during reset; the single wrb pulse that follows carries db = 8'h81.

Source files
------------

// File: rtl/s2p_deser.sv
// s2p_deser: serial-to-parallel converter.
// Bits arriving on da while wra_n is low are collected into a WIDTH-bit word.
// When the word is complete it is presented on db, and wrb pulses for one cycle.
// All outputs are registered; there is no combinational path from inputs to outputs.
module s2p_deser #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clka,
   input  logic             rstn,
   input  logic             wra_n,
   input  logic             da,
   output logic             wrb,
   output logic [WIDTH-1:0] db
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] db_reg, db_next;
   logic             wrb_reg, wrb_next;

   // Shift register contents after sampling da. MSB-first shifts left with the
   // new bit entering bit 0. LSB-first shifts right with the new bit entering
   // the top bit.
   genvar gi;
   for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
         if (gi == 0) begin : g_in
            assign shifted[gi] = da;
         end else begin : g_mv
            assign shifted[gi] = shift_reg[gi-1];
         end
      end else begin : g_lsb
         if (gi == WIDTH - 1) begin : g_in
            assign shifted[gi] = da;
         end else begin : g_mv
            assign shifted[gi] = shift_reg[gi+1];
         end
      end
   end

   // Next-state logic. The sampling path, word completion, and abort all live here.
   always_comb begin
      shift_next = shift_reg;
      cnt_next   = cnt_reg;
      db_next    = db_reg;
      wrb_next   = 1'b0;
      if (!wra_n) begin
         shift_next = shifted;
         if (cnt_reg == LAST_CNT) begin
            // The bit sampled on this edge completes the word.
            db_next  = shifted;
            wrb_next = 1'b1;
            cnt_next = '0;
         end else begin
            cnt_next = cnt_reg + CW'(1);
         end
      end else begin
         // Abort or idle. Drop the partial word. da is not looked at, so
         // X or Z values on da cannot reach the state.
         shift_next = '0;
         cnt_next   = '0;
      end
   end

   // State registers. An asynchronous reset clears everything immediately.
   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
         db_reg    <= '0;
         wrb_reg   <= 1'b0;
      end else begin
         shift_reg <= shift_next;
         cnt_reg   <= cnt_next;
         db_reg    <= db_next;
         wrb_reg   <= wrb_next;
      end
   end

   assign wrb = wrb_reg;
   assign db  = db_reg;

endmodule

// File: tb/tb_s2p_deser.sv
// tb_s2p_deser: testbench for s2p_deser.
// One MSB-first instance and one LSB-first instance share the same stimulus.
// A queue-based word model predicts wrb and db for both instances on every cycle.
module tb_s2p_deser;

   localparam int W = 8;

   logic         clka  = 1'b0;
   logic         rstn  = 1'b1;
   logic         wra_n = 1'b1;
   logic         da    = 1'b0;
   logic         wrb_m, wrb_l;
   logic [W-1:0] db_m, db_l;

   int n_vec = 0;
   int n_err = 0;
   int n_words = 0;

   // Reference state: bits of the current frame in arrival order, plus the expected outputs.
   bit           frame_q[$];
   logic [W-1:0] exp_db_m = '0;
   logic [W-1:0] exp_db_l = '0;
   logic         exp_wrb  = 1'b0;

   s2p_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clka (clka),
      .rstn (rstn),
      .wra_n(wra_n),
      .da   (da),
      .wrb  (wrb_m),
      .db   (db_m)
   );

   s2p_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clka (clka),
      .rstn (rstn),
      .wra_n(wra_n),
      .da   (da),
      .wrb  (wrb_l),
      .db   (db_l)
   );

   always #5 clka = ~clka;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Model for one rising edge, using the inputs that were present at that edge.
   task automatic model_edge();
      if (!rstn) begin
         frame_q.delete();
         exp_wrb  = 1'b0;
         exp_db_m = '0;
         exp_db_l = '0;
      end else if (wra_n) begin
         frame_q.delete();
         exp_wrb = 1'b0;
      end else begin
         frame_q.push_back(da);
         exp_wrb = 1'b0;
         if (frame_q.size() == W) begin
            for (int i = 0; i < W; i++) begin
               exp_db_m[W-1-i] = frame_q[i];
               exp_db_l[i]     = frame_q[i];
            end
            exp_wrb = 1'b1;
            frame_q.delete();
            n_words++;
            $display("word %0d at %0t: msb-first %02h, lsb-first %02h",
                     n_words, $time, exp_db_m, exp_db_l);
         end
      end
   endtask

   task automatic check_outs(input string tag);
      check_value({tag, "/wrb_m"}, {31'd0, wrb_m}, {31'd0, exp_wrb});
      check_value({tag, "/wrb_l"}, {31'd0, wrb_l}, {31'd0, exp_wrb});
      check_value({tag, "/db_m"},  {24'd0, db_m},  {24'd0, exp_db_m});
      check_value({tag, "/db_l"},  {24'd0, db_l},  {24'd0, exp_db_l});
   endtask

   // Drive the inputs, let one edge pass, then check #1 after that edge.
   task automatic step(input logic wr, input logic d, input string tag);
      wra_n = wr;
      da    = d;
      @(posedge clka);
      #1;
      model_edge();
      check_outs(tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'bx, "idle");
   endtask

   task automatic send_word(input logic [W-1:0] w, input string tag);
      for (int i = W - 1; i >= 0; i--) step(1'b0, w[i], tag);
   endtask

   // Assert reset in the middle of a cycle and check that the outputs clear with no edge.
   // Keep reset low across one edge, then release it away from the edge.
   task automatic async_reset(input string tag);
      #3;
      rstn = 1'b0;
      #1;
      frame_q.delete();
      exp_wrb  = 1'b0;
      exp_db_m = '0;
      exp_db_l = '0;
      check_outs({tag, "_async"});
      step(1'b1, 1'bx, {tag, "_held"});
      rstn = 1'b1;
   endtask

   initial begin
      // Reset at start-up. The outputs must clear before any clock edge arrives.
      #1;
      rstn = 1'b0;
      #1;
      check_outs("reset0");
      @(posedge clka);
      #1;
      rstn = 1'b1;
      idle(2);

      // Single MSB-first frame: 1,0,1,1,0,0,1,0 gives B2.
      send_word(8'hB2, "frame_b2");
      check_value("b2_db", {24'd0, db_m}, 32'h0000_00B2);
      check_value("b2_wrb", {31'd0, wrb_m}, 32'd1);
      idle(3);
      check_value("b2_hold", {24'd0, db_m}, 32'h0000_00B2);

      // Back-to-back frames with wra_n held low for 16 edges.
      send_word(8'hFF, "b2b_ff");
      check_value("b2b_ff_db", {24'd0, db_m}, 32'h0000_00FF);
      send_word(8'h01, "b2b_01");
      check_value("b2b_01_db", {24'd0, db_m}, 32'h0000_0001);
      idle(1);

      // Abort in mid-frame: A5, then 3 bits, then wra_n high for 2 cycles, then 3C.
      send_word(8'hA5, "abort_a5");
      step(1'b0, 1'b1, "abort_p");
      step(1'b0, 1'b0, "abort_p");
      step(1'b0, 1'b1, "abort_p");
      idle(2);
      check_value("abort_hold", {24'd0, db_m}, 32'h0000_00A5);
      send_word(8'h3C, "abort_3c");
      check_value("abort_3c_db", {24'd0, db_m}, 32'h0000_003C);
      idle(2);

      // LSB-first build: 1 then seven 0s gives 01 (the MSB-first instance gives 80).
      send_word(8'h80, "lsb_first");
      check_value("lsb_db", {24'd0, db_l}, 32'h0000_0001);
      idle(2);

      // Reset in mid-frame: 5 bits, reset pulse, then 81.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "rst_part");
      async_reset("rst_mid");
      send_word(8'h81, "rst_81");
      check_value("rst_81_db", {24'd0, db_m}, 32'h0000_0081);
      idle(2);

      // Random traffic: mostly sampling, with occasional aborts and resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset("rnd_rst");
         end else begin
            step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "rnd");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
